// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
//  Module      : note_player
//  Description : Maps a 7-bit tempo step index to a C-major scale note
//                (C4..C5, one note per group of 8 steps) and drives a square
//                wave speaker output at that pitch. An articulation gap of
//                silence is inserted before every new note.
//  Revision    : 1.0  initial release
// ============================================================================
module note_player #(
  parameter int GAP_CYCLES = 2500000,
  parameter int DIV_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] step,
  input  logic       enable,
  output logic       speaker,
  output logic [2:0] note_idx,
  output logic       playing,
  output logic       note_strobe
);

  typedef enum logic [1:0] {
    ST_REST = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2
  } state_t;

  // Gap counter load value; unused when the gap is disabled.
  localparam logic [21:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 22'(GAP_CYCLES - 1) : 22'd0;
  localparam bit          c_HAS_GAP  = (GAP_CYCLES > 0);

  // Half-period of each scale note in 50 MHz cycles, optionally shortened.
  function automatic logic [16:0] f_half(input logic [2:0] idx);
    logic [16:0] base;
    case (idx)
      3'd0:    base = 17'd95556;  // C4
      3'd1:    base = 17'd85131;  // D4
      3'd2:    base = 17'd75843;  // E4
      3'd3:    base = 17'd71586;  // F4
      3'd4:    base = 17'd63776;  // G4
      3'd5:    base = 17'd56818;  // A4
      3'd6:    base = 17'd50619;  // B4
      default: base = 17'd47778;  // C5
    endcase
    return base >> DIV_SHIFT;
  endfunction

  state_t      r_state;
  logic [3:0]  r_cur_slot;
  logic [21:0] r_gap_cnt;
  logic [16:0] r_div_cnt;
  logic        r_speaker;
  logic [2:0]  r_note_idx;
  logic        r_playing;
  logic        r_note_strobe;

  state_t      w_state_nx;
  logic [3:0]  w_slot_nx;
  logic [21:0] w_gap_nx;
  logic [16:0] w_div_nx;
  logic        w_spk_nx;
  logic [2:0]  w_idx_nx;
  logic        w_play_nx;
  logic        w_strobe_nx;

  logic [3:0]  w_slot;
  logic [16:0] w_half_m1;
  logic        w_unused_step_lsb;

  // Each group of 8 steps is one slot; the position inside the slot is irrelevant.
  assign w_slot            = step[6:3];
  assign w_unused_step_lsb = ^step[2:0];
  assign w_half_m1         = f_half(r_note_idx) - 17'd1;

  // Next-state and next-output logic, evaluated in strict priority order.
  always_comb begin
    w_state_nx  = r_state;
    w_slot_nx   = r_cur_slot;
    w_gap_nx    = r_gap_cnt;
    w_div_nx    = r_div_cnt;
    w_spk_nx    = r_speaker;
    w_idx_nx    = r_note_idx;
    w_play_nx   = r_playing;
    w_strobe_nx = 1'b0;

    if (!enable) begin
      // Forget the slot so that re-enabling always restarts the note.
      w_state_nx = ST_REST;
      w_slot_nx  = 4'hF;
      w_spk_nx   = 1'b0;
      w_play_nx  = 1'b0;
    end else if (w_slot != r_cur_slot) begin
      // A new slot aborts whatever was sounding, with no partial pulse.
      w_slot_nx = w_slot;
      w_spk_nx  = 1'b0;
      w_play_nx = 1'b0;
      if (w_slot[3]) begin
        w_state_nx = ST_REST;
      end else begin
        w_idx_nx = w_slot[2:0];
        if (c_HAS_GAP) begin
          w_state_nx = ST_GAP;
          w_gap_nx   = c_GAP_LOAD;
        end else begin
          w_state_nx  = ST_TONE;
          w_spk_nx    = 1'b1;
          w_div_nx    = 17'd0;
          w_play_nx   = 1'b1;
          w_strobe_nx = 1'b1;
        end
      end
    end else begin
      case (r_state)
        ST_REST: begin
          w_spk_nx  = 1'b0;
          w_play_nx = 1'b0;
        end
        ST_GAP: begin
          w_spk_nx = 1'b0;
          if (r_gap_cnt == 22'd0) begin
            // Tone starts high with a fresh divider.
            w_state_nx  = ST_TONE;
            w_spk_nx    = 1'b1;
            w_div_nx    = 17'd0;
            w_play_nx   = 1'b1;
            w_strobe_nx = 1'b1;
          end else begin
            w_gap_nx = r_gap_cnt - 22'd1;
          end
        end
        ST_TONE: begin
          if (r_div_cnt == w_half_m1) begin
            w_spk_nx = ~r_speaker;
            w_div_nx = 17'd0;
          end else begin
            w_div_nx = r_div_cnt + 17'd1;
          end
        end
        default: begin
          w_state_nx = ST_REST;
          w_spk_nx   = 1'b0;
          w_play_nx  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_REST;
      r_cur_slot    <= 4'hF;
      r_gap_cnt     <= 22'd0;
      r_div_cnt     <= 17'd0;
      r_speaker     <= 1'b0;
      r_note_idx    <= 3'd0;
      r_playing     <= 1'b0;
      r_note_strobe <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cur_slot    <= w_slot_nx;
      r_gap_cnt     <= w_gap_nx;
      r_div_cnt     <= w_div_nx;
      r_speaker     <= w_spk_nx;
      r_note_idx    <= w_idx_nx;
      r_playing     <= w_play_nx;
      r_note_strobe <= w_strobe_nx;
    end
  end

  assign speaker     = r_speaker;
  assign note_idx    = r_note_idx;
  assign playing     = r_playing;
  assign note_strobe = r_note_strobe;

endmodule
`default_nettype wire

// File: tb/tb_note_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_player
//  Description : Scoreboard bench for note_player. Stimulus pushes expected
//                output events (strobe, speaker edge, playing fall) with the
//                clock edge they must occur on; a monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_note_player;

  localparam int K_STROBE = 0;
  localparam int K_SPK    = 1;
  localparam int K_OFF    = 2;
  localparam int GAP      = 4;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] step;
  logic       enable;
  logic       speaker;
  logic [2:0] note_idx;
  logic       playing;
  logic       note_strobe;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  logic p_spk;
  logic p_play;
  ev_t q[$];

  note_player #(
    .GAP_CYCLES(GAP),
    .DIV_SHIFT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .enable     (enable),
    .speaker    (speaker),
    .note_idx   (note_idx),
    .playing    (playing),
    .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Expected events of a note whose slot change lands on edge n and which is
  // interrupted (disable, slot change, reset) at edge stop.
  task automatic play(input int n, input int note, input int half, input int stop);
    int t;
    int lvl;
    t   = n + GAP;
    lvl = 0;
    if (t < stop) begin
      push(K_STROBE, note, t);
      for (int k = 0; t + k * half < stop; k++) begin
        lvl = (k % 2 == 0) ? 1 : 0;
        push(K_SPK, lvl, t + k * half);
      end
      if (lvl == 1) push(K_SPK, 0, stop);
      push(K_OFF, 0, stop);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind %0d val %0d at cycle %0d, none expected",
               kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Make an input change visible just before edge e (drives on a negedge).
  task automatic drive_at(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  // Monitor: every observable output event is matched against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (note_strobe) observe(K_STROBE, int'(note_idx));
      if (speaker !== p_spk) observe(K_SPK, int'(speaker));
      if (p_play && !playing) observe(K_OFF, 0);
      p_spk  = speaker;
      p_play = playing;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0, s1, n1, t1, s2, n2, t2, s3, s4, n3, t3, s5;
    int n4, t4, s6, n5, t5, s7, n6, s8, n7, t7, s9;

    rst    = 1'b0;
    enable = 1'b1;
    step   = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_speaker", int'(speaker), 0);
    check("rst_note_idx", int'(note_idx), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_strobe", int'(note_strobe), 0);
    p_spk  = 1'b0;
    p_play = 1'b0;
    mon_en = 1'b1;

    // Release reset with step 0: gap then C4 (half 373).
    n0 = cyc + 1; t0 = n0 + GAP; s1 = t0 + 900;
    play(n0, 0, 373, s1);
    rst = 1'b1;

    // 0 -> 8 mid-tone: D4 (half 332).
    drive_at(s1); step = 7'd8;
    n1 = s1; t1 = n1 + GAP; s2 = t1 + 1200;
    play(n1, 1, 332, s2);

    // 8 -> 15 inside the same slot: no effect on phase.
    drive_at(t1 + 500); step = 7'd15;

    // 15 -> 63: C5 (half 186).
    drive_at(s2); step = 7'd63;
    n2 = s2; t2 = n2 + GAP; s3 = t2 + 400;
    play(n2, 7, 186, s3);

    // 63 -> 64..69: rest.
    drive_at(s3); step = 7'd64;
    for (int k = 65; k <= 69; k++) begin
      drive_at(s3 + 5 * (k - 64));
      step = 7'(k);
    end
    check("rest_playing", int'(playing), 0);
    check("rest_speaker", int'(speaker), 0);
    check("rest_note_hold", int'(note_idx), 7);

    // 69 -> 0 wrap: gap then C4.
    s4 = s3 + 30;
    drive_at(s4); step = 7'd0;
    n3 = s4; t3 = n3 + GAP; s5 = t3 + 500;
    play(n3, 0, 373, s5);

    // Step 56: C5, then one-cycle disable during TONE.
    drive_at(s5); step = 7'd56;
    n4 = s5; t4 = n4 + GAP; s6 = t4 + 100;
    play(n4, 7, 186, s6);
    drive_at(s6); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    check("dis_speaker", int'(speaker), 0);
    check("dis_playing", int'(playing), 0);
    n5 = s6 + 1; t5 = n5 + GAP; s7 = t5 + 200;
    play(n5, 7, 186, s7);

    // Step 24 (F4, half 279), reset two cycles into the gap.
    drive_at(s7); step = 7'd24;
    n6 = s7; s8 = n6 + 2;
    play(n6, 3, 279, s8);
    drive_at(s8); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("mrst_speaker", int'(speaker), 0);
    check("mrst_note_idx", int'(note_idx), 0);
    check("mrst_playing", int'(playing), 0);
    check("mrst_strobe", int'(note_strobe), 0);
    n7 = s8 + 1; t7 = n7 + GAP; s9 = t7 + 800;
    play(n7, 3, 279, s9);

    drive_at(s9); enable = 1'b0;
    repeat (5) @(negedge clk);
    check("events_left", q.size(), 0);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      $display("FAIL missing_event: kind %0d val %0d cycle %0d", e.kind, e.val, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_player.md
# note_player

Downstream consumer of the tempo step counter. Takes its 7-bit step index (0..69, one step per tempo tick), maps each group of 8 steps to one note of the C-major scale (C4..C5), and drives a square-wave speaker output at that note's pitch. A short articulation gap is inserted at every note change so that consecutive notes are audibly separated. Steps 64..69 play a rest before the counter wraps.

## Interface
- GAP_CYCLES, default 2500000: silent cycles inserted before each new note (50 ms at 50 MHz); 0 means no gap.
- DIV_SHIFT, default 0: right-shift applied to every half-period constant, used only to shorten simulation.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; one clock, reset is synchronous and active-low.
- step  input  7  step index from the tempo counter.
- enable  input  1  1 = play; 0 = forced silence.
- speaker  output  1  square-wave audio output.
- note_idx  output  3  current note number (0 = C4 .. 7 = C5); holds its last value outside TONE.
- playing  output  1  high while in TONE.
- note_strobe  output  1  one-cycle pulse on the cycle TONE is entered.

## Operation
- slot = step[6:3] (4 bits). Slots 0..7 are notes; slots 8..15 are rest. Steps 64..69 and any out-of-range value map to rest.
- Half-period constants (cycles at 50 MHz, 17 bits), each >> DIV_SHIFT: 0 = 95556, 1 = 85131, 2 = 75843, 3 = 71586, 4 = 63776, 5 = 56818, 6 = 50619, 7 = 47778.
- Registers: state, cur_slot (4 bits), gap_cnt (22 bits), div_cnt (17 bits), speaker, note_idx, playing, note_strobe.
- States are REST, GAP and TONE. The priority order below applies every cycle.
  - rst = 0: state = REST, cur_slot = 4'hF, gap_cnt = 0, div_cnt = 0, speaker = 0, note_idx = 0, playing = 0, note_strobe = 0.
  - enable = 0: state goes to REST, speaker = 0, cur_slot = 4'hF. Re-enabling always retriggers, even on the same slot.
  - slot != cur_slot:
    - cur_slot is loaded with slot.
    - If slot >= 8: go to REST.
    - Otherwise: note_idx = slot[2:0] and speaker = 0.
    - If GAP_CYCLES > 0: go to GAP with gap_cnt = GAP_CYCLES-1.
    - If GAP_CYCLES = 0: go directly to TONE, using the TONE entry actions.
    - A slot change during GAP or TONE aborts the current note immediately.
  - REST: speaker = 0, playing = 0.
  - GAP: speaker = 0. gap_cnt decrements; when gap_cnt = 0 the next state is TONE.
  - TONE entry (edge into TONE): speaker = 1, div_cnt = 0, playing = 1, note_strobe = 1 for exactly that one cycle.
  - TONE: div_cnt increments. When div_cnt = HALF[note_idx]-1, speaker toggles and div_cnt = 0.
- note_strobe is 0 in all other cycles.

## Timing
- The step input is sampled combinationally against cur_slot. A slot change visible before edge N updates state, cur_slot and note_idx at edge N (one-cycle latency).
- GAP lasts exactly GAP_CYCLES cycles. TONE is entered at edge N+GAP_CYCLES.
- In TONE, speaker is high for exactly HALF cycles, then low for exactly HALF cycles. The period is 2*HALF, and the first half-cycle is high.
- speaker is 0 in the first cycle after any slot change, reset or disable. There is no partial high pulse.
- Step changes within the same slot (for example 8 → 9) have no effect: no gap, and the phase is preserved.
- When the step wraps from 69 to 0 (rest → C4), a gap is inserted and then C4 starts.
- Reset or disable asserted mid-note takes effect at the next edge, overriding everything else.

## Test plan
All scenarios use DIV_SHIFT = 8 and GAP_CYCLES = 4.
- Reset, enable = 1, step = 0. Required: 4 cycles GAP with speaker = 0, then a note_strobe pulse with note_idx = 0. Speaker then toggles every 373 cycles, high first.
- Step 0 → 8 mid-tone. Required: speaker = 0 on the next edge, 4 gap cycles, then note_idx = 1 with a half-period of 332 cycles.
- Step 8 → 15. Required: no gap, no strobe, and the toggle phase is unchanged.
- Step 63 → 64. Required: state goes to REST, playing = 0, and speaker stays 0 through step 69. Then step 69 → 0 gives a gap followed by C4.
- enable is dropped for 1 cycle during TONE with step = 56. Required: speaker = 0 and REST. On re-enable, a 4-cycle gap, then a strobe with note_idx = 7 and a half-period of 186.
- rst = 0 asserted mid-GAP. Required: every output is 0 at the next edge. After release, the current slot restarts with a full gap.
